// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble, flush, forwarding selects and perf counters.
// Optional macro HAZARD_FWD_EN enables EX/MEM forwarding; undefined, every dependence stalls.
module hazard_ctrl #(
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] D_ra,
  input  logic [RADDR_W-1:0] D_rb,
  input  logic               D_use_a,
  input  logic               D_use_b,
  input  logic [RADDR_W-1:0] EX_rd,
  input  logic               EX_we,
  input  logic               EX_ld,
  input  logic [RADDR_W-1:0] MEM_rd,
  input  logic               MEM_we,
  input  logic [RADDR_W-1:0] WB_rd,
  input  logic               WB_we,
  input  logic               EX_taken,
  output logic               F_hold,
  output logic               D_bubble,
  output logic               F_flush,
  output logic               D_flush,
  output logic [1:0]         EX_fwd_a,
  output logic [1:0]         EX_fwd_b,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               hit_a_ex, hit_b_ex, hit_a_mem, hit_b_mem, hit_a_wb, hit_b_wb;
  logic               masked, stall_req;

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       quiet;
`else
  logic       unused_ld;
  assign unused_ld = EX_ld;
`endif

  always_comb begin
    hit_a_ex  = D_use_a && EX_we  && (D_ra == EX_rd);
    hit_b_ex  = D_use_b && EX_we  && (D_rb == EX_rd);
    hit_a_mem = D_use_a && MEM_we && (D_ra == MEM_rd);
    hit_b_mem = D_use_b && MEM_we && (D_rb == MEM_rd);
    hit_a_wb  = D_use_a && WB_we  && (D_ra == WB_rd);
    hit_b_wb  = D_use_b && WB_we  && (D_rb == WB_rd);
    // D holds a cleared instruction during FLUSH, so no hazard can exist
    masked    = (state_q == FLUSH);
`ifdef HAZARD_FWD_EN
    stall_req = !masked && (((hit_a_ex || hit_b_ex) && EX_ld) || hit_a_wb || hit_b_wb);
`else
    stall_req = !masked && (hit_a_ex || hit_b_ex || hit_a_mem || hit_b_mem ||
                            hit_a_wb || hit_b_wb);
`endif
    F_flush  = !rst && EX_taken;
    D_flush  = !rst && EX_taken;
    F_hold   = !rst && !EX_taken && stall_req;
    D_bubble = !rst && !EX_taken && stall_req;

    if (EX_taken)       state_d = FLUSH;
    else if (masked)    state_d = RUN;
    else if (stall_req) state_d = STALL;
    else                state_d = RUN;

`ifdef HAZARD_FWD_EN
    quiet   = F_hold || EX_taken || masked;
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!quiet) begin
      if (hit_a_ex && !EX_ld) fwd_a_d = 2'b01;
      else if (hit_a_mem)     fwd_a_d = 2'b10;
      if (hit_b_ex && !EX_ld) fwd_b_d = 2'b01;
      else if (hit_b_mem)     fwd_b_d = 2'b10;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
`ifdef HAZARD_FWD_EN
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (F_hold && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + 1'b1;
      if (EX_taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
`ifdef HAZARD_FWD_EN
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
`endif
    end
  end

`ifdef HAZARD_FWD_EN
  assign EX_fwd_a = fwd_a_q;
  assign EX_fwd_b = fwd_b_q;
`else
  assign EX_fwd_a = '0;
  assign EX_fwd_b = '0;
`endif
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan cycles then random cycles,
// checked against a rule-level reference model (follows HAZARD_FWD_EN like the DUT).
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int N_DIR   = 12;
  localparam int N_RAND  = 1500;
  localparam int N_ITEMS = N_DIR + N_RAND;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] D_ra, D_rb, EX_rd, MEM_rd, WB_rd;
  logic       D_use_a, D_use_b, EX_we, EX_ld, MEM_we, WB_we, EX_taken;
  logic       F_hold, D_bubble, F_flush, D_flush;
  logic [1:0] EX_fwd_a, EX_fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.RADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .D_ra(D_ra), .D_rb(D_rb), .D_use_a(D_use_a), .D_use_b(D_use_b),
    .EX_rd(EX_rd), .EX_we(EX_we), .EX_ld(EX_ld),
    .MEM_rd(MEM_rd), .MEM_we(MEM_we), .WB_rd(WB_rd), .WB_we(WB_we),
    .EX_taken(EX_taken),
    .F_hold(F_hold), .D_bubble(D_bubble), .F_flush(F_flush), .D_flush(D_flush),
    .EX_fwd_a(EX_fwd_a), .EX_fwd_b(EX_fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hold, bub, ff, df;
    int fa, fb, sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state: what the registered outputs show now, and whether the
  // previous accepted cycle was a taken branch (so D now holds a squashed slot).
  int m_fa = 0, m_fb = 0, m_sc = 0, m_fc = 0;
  bit m_after_taken = 0;
  int SAT = (1 << CNT_W) - 1;

  task automatic clear_in();
    rst = 0; D_ra = 0; D_rb = 0; D_use_a = 0; D_use_b = 0;
    EX_rd = 0; EX_we = 0; EX_ld = 0; MEM_rd = 0; MEM_we = 0;
    WB_rd = 0; WB_we = 0; EX_taken = 0;
  endtask

  task automatic model_push();
    exp_t e;
    bit ha_ex, hb_ex, ha_mem, hb_mem, ha_wb, hb_wb, need, was_flush;
    ha_ex  = D_use_a && EX_we  && (D_ra == EX_rd);
    hb_ex  = D_use_b && EX_we  && (D_rb == EX_rd);
    ha_mem = D_use_a && MEM_we && (D_ra == MEM_rd);
    hb_mem = D_use_b && MEM_we && (D_rb == MEM_rd);
    ha_wb  = D_use_a && WB_we  && (D_ra == WB_rd);
    hb_wb  = D_use_b && WB_we  && (D_rb == WB_rd);
`ifdef HAZARD_FWD_EN
    need = ((ha_ex || hb_ex) && EX_ld) || ha_wb || hb_wb;
`else
    need = ha_ex || hb_ex || ha_mem || hb_mem || ha_wb || hb_wb;
`endif
    if (m_after_taken) need = 0;
    e.hold = !rst && !EX_taken && need;
    e.bub  = e.hold;
    e.ff   = !rst && EX_taken;
    e.df   = e.ff;
    e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);

    was_flush = m_after_taken;
    if (rst) begin
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_after_taken = 0;
    end else begin
      if (e.hold)   m_sc = (m_sc + 1 > SAT) ? SAT : m_sc + 1;
      if (EX_taken) m_fc = (m_fc + 1 > SAT) ? SAT : m_fc + 1;
      m_after_taken = EX_taken;
      m_fa = 0; m_fb = 0;
`ifdef HAZARD_FWD_EN
      if (!(e.hold || EX_taken || was_flush)) begin
        m_fa = (ha_ex && !EX_ld) ? 1 : (ha_mem ? 2 : 0);
        m_fb = (hb_ex && !EX_ld) ? 1 : (hb_mem ? 2 : 0);
      end
`endif
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Driver: one stimulus item per clock, applied just after the edge
  initial begin
    clear_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N_ITEMS; i++) begin
      clear_in();
      case (i)
        0:  begin EX_we = 1; EX_rd = 3; D_ra = 3; D_use_a = 1; end
        1:  begin EX_ld = 1; EX_we = 1; EX_rd = 4; D_rb = 4; D_use_b = 1; end
        2:  begin MEM_we = 1; MEM_rd = 4; D_rb = 4; D_use_b = 1; end
        3:  begin WB_we = 1; WB_rd = 7; D_ra = 7; D_use_a = 1; end
        4:  begin D_ra = 7; D_use_a = 1; end
        5:  begin EX_taken = 1; EX_ld = 1; EX_we = 1; EX_rd = 4; D_rb = 4; D_use_b = 1; end
        6:  begin EX_ld = 1; EX_we = 1; EX_rd = 4; D_rb = 4; D_use_b = 1; end
        7:  begin EX_ld = 1; EX_we = 1; EX_rd = 9; D_ra = 9; D_use_a = 1; end
        8:  begin rst = 1; EX_ld = 1; EX_we = 1; EX_rd = 9; D_ra = 9; D_use_a = 1; end
        9:  begin EX_we = 1; EX_rd = 5; D_ra = 5; D_use_a = 1; end
        10: begin MEM_we = 1; MEM_rd = 5; D_ra = 5; D_use_a = 1; end
        11: begin WB_we = 1; WB_rd = 5; D_ra = 5; D_use_a = 1; end
        default: begin
          rst      = ($urandom_range(0, 59) == 0);
          EX_taken = ($urandom_range(0, 7) == 0);
          D_use_a  = $urandom_range(0, 1);
          D_use_b  = $urandom_range(0, 1);
          EX_we    = $urandom_range(0, 1);
          EX_ld    = $urandom_range(0, 1);
          MEM_we   = $urandom_range(0, 1);
          WB_we    = $urandom_range(0, 1);
          D_ra     = 5'($urandom_range(0, 3));
          D_rb     = 5'($urandom_range(0, 3));
          EX_rd    = 5'($urandom_range(0, 3));
          MEM_rd   = 5'($urandom_range(0, 3));
          WB_rd    = 5'($urandom_range(0, 3));
        end
      endcase
      model_push();
      @(posedge clk);
      #1;
    end
    clear_in();
  end

  // Monitor: compares the DUT mid-cycle against the oldest pending expectation
  initial begin
    exp_t e;
    int got  = 0;
    int idle = 0;
    while (got < N_ITEMS && idle < 50) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("F_hold",    32'(F_hold),    32'(e.hold));
        chk("D_bubble",  32'(D_bubble),  32'(e.bub));
        chk("F_flush",   32'(F_flush),   32'(e.ff));
        chk("D_flush",   32'(D_flush),   32'(e.df));
        chk("EX_fwd_a",  32'(EX_fwd_a),  32'(e.fa));
        chk("EX_fwd_b",  32'(EX_fwd_b),  32'(e.fb));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
        got++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    if (got < N_ITEMS) begin
      n_total++;
      $display("FAIL timeout: got %0d items expected %0d", got, N_ITEMS);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It watches the register fields and control bits of the D, EX, MEM and WB stages plus the EX branch outcome. It drives PC/F→D hold, D→EX bubble insertion, F→D and D→EX flush, and registered forwarding selects consumed by the EX operand muxes. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- RADDR_W, 5, register-address width
- CNT_W, 16, width of each performance counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- D_ra  in  RADDR_W  D-stage source A register
- D_rb  in  RADDR_W  D-stage source B register
- D_use_a  in  1  D instruction reads D_ra
- D_use_b  in  1  D instruction reads D_rb
- EX_rd  in  RADDR_W  EX destination
- EX_we  in  1  EX writes register
- EX_ld  in  1  EX is a load
- MEM_rd  in  RADDR_W  MEM destination
- MEM_we  in  1  MEM writes register
- WB_rd  in  RADDR_W  WB destination
- WB_we  in  1  WB writes register
- EX_taken  in  1  EX branch resolved taken
- F_hold  out  1  hold PC and F→D register
- D_bubble  out  1  load NOP (all control bits 0) into D→EX
- F_flush  out  1  clear F→D register
- D_flush  out  1  clear D→EX register
- EX_fwd_a  out  2  operand A source in EX: 00 regfile, 01 MEM_alu_out, 10 WB_data_mem
- EX_fwd_b  out  2  operand B source, same encoding
- stall_cnt  out  CNT_W  cycles with F_hold=1
- flush_cnt  out  CNT_W  taken-branch flushes

## Operation
- Match terms: srcX_hit_S = D_use_X && S_we && (D_rX == S_rd), S ∈ {EX, MEM, WB}. Register 0 is an ordinary register; no special case.
- Load-use: any srcX_hit_EX with EX_ld=1 requires a stall.
- WB collision: any srcX_hit_WB requires a stall, because the regfile has no write-through. The D instruction re-reads after the write edge.
- Stall: F_hold=1 and D_bubble=1 in the same cycle.
- Forward select for each operand is computed in D and registered at the D→EX edge:
  - srcX_hit_EX with no load gives 01.
  - Otherwise srcX_hit_MEM gives 10.
  - Otherwise 00.
  - EX takes priority over MEM (youngest writer wins).
- During stall or flush cycles, the registered selects load 00.
- State machine, with states RUN, STALL, FLUSH:
  - RUN → STALL when a stall is required.
  - STALL → RUN when no stall is required.
  - Any state → FLUSH when EX_taken=1.
  - FLUSH → RUN unconditionally after one cycle.
- In FLUSH, the D stage holds a cleared instruction, so all hazard terms are masked: no stall, selects 00.
- Flush: EX_taken=1 drives F_flush=1 and D_flush=1 combinationally. Flush overrides stall: F_hold=0 and D_bubble=0 in that cycle.
- stall_cnt increments on each cycle with F_hold=1. flush_cnt increments on each cycle with EX_taken=1. Both saturate at all-ones.

## Timing
- F_hold, D_bubble, F_flush and D_flush are combinational from the current inputs and state, and take effect at the next clk edge.
- EX_fwd_a and EX_fwd_b are registered, with 1-cycle latency from D to EX.
- Load-use costs exactly 1 stall cycle; the consumer then receives select 10 in EX.
- WB collision costs exactly 1 stall cycle.
- Taken branch costs 2 squashed instructions and 1 FLUSH cycle.
- Reset values: state RUN, EX_fwd_a=00, EX_fwd_b=00, stall_cnt=0, flush_cnt=0. F_hold, D_bubble, F_flush and D_flush are 0 while rst=1, regardless of inputs.
- Reset asserted mid-stall or mid-flush forces RUN at the next edge; counters clear.
- EX_taken coincident with load-use: flush wins, and the load-use is not counted as a stall.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described above.
- HAZARD_FWD_EN undefined:
  - EX_fwd_a and EX_fwd_b are tied to 00.
  - Any srcX_hit_EX, srcX_hit_MEM or srcX_hit_WB requires a stall.
  - A dependent instruction stalls until the producer has left WB: up to 3 cycles for a back-to-back dependence.
  - Flush behaviour is unchanged.

## Test plan
- ALU back-to-back: add r3 in EX (EX_we=1, EX_rd=3), D_ra=3 with D_use_a=1 -> F_hold=0; next cycle EX_fwd_a=01; stall_cnt unchanged.
- Load-use: EX_ld=1, EX_rd=4, D_rb=4 with D_use_b=1 -> F_hold=1 and D_bubble=1 for 1 cycle; with the load now in MEM, the following cycle has EX_fwd_b=10; stall_cnt=1.
- WB collision: WB_we=1, WB_rd=7, D_ra=7 -> 1 stall cycle, then EX_fwd_a=00.
- Taken branch with simultaneous load-use: EX_taken=1 -> F_flush=1, D_flush=1, F_hold=0; next cycle is FLUSH with hazards masked; flush_cnt=1, stall_cnt=0.
- Reset mid-stall: rst=1 during STALL -> all outputs 0 and counters 0 at the next edge.
- Without HAZARD_FWD_EN: dependence on EX_rd=5 (non-load) -> F_hold=1 for 3 cycles, EX_fwd_a always 00; stall_cnt=3.
